mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle MIPS control unit that sequences the shared single-ALU datapath: PC, IR, register file, ALU, memory port and the 16→32 immediate extender.
- Decodes opcode from IR and steps each instruction through fetch/decode/execute/memory/writeback states.
- Stalls on a memory ready handshake, selects sign vs zero extension per instruction, and traps illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles in a memory state before trapping; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  IR[31:26], stable from DECODE to end of instruction
- mem_ready  in  1  memory completes the access this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if ALU zero
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  0 = PC address, 1 = ALUOut address
- memread  out  1  read request
- memwrite  out  1  write request
- irwrite  out  1  IR load
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = MDR, 0 = ALUOut
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct, 11 logical-by-op
- ext_sign  out  1  1 = sign extend imm[15], 0 = zero fill
- illegal_op  out  1  sticky, unsupported opcode
- mem_timeout  out  1  sticky, memory timeout trap
- retired  out  CNT_W  instructions completed, wraps
- state_dbg  out  4  current state encoding

Behaviour:
- State register updates on rising clk. reset forces FETCH asynchronously and clears wait counter, retired, illegal_op and mem_timeout.
- Outputs are Moore decodes of state, except irwrite/pcwrite in FETCH, which are qualified by mem_ready.
- Default for every output is 0, except ext_sign=1.
- In reset (FETCH): memread=1, alusrcb=01, all else default.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, ERROR 12.
- FETCH: memread, iord=0, alusrca=0, alusrcb=01, aluop=00. Holds until mem_ready; in that cycle irwrite=pcwrite=1, then → DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 lw / 101011 sw → MEMADR
  - 000000 → RTEX
  - 000100 → BEQEX
  - 001000 addi, 001100 andi, 001101 ori → IMMEX
  - 000010 → JEX
  - other → ERROR with illegal_op set.
- MEMADR: alusrca=1, alusrcb=10, aluop=00; → MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1, memread; hold until mem_ready, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite → FETCH.
- MEMWR: iord=1, memwrite; hold until mem_ready, then → FETCH.
- RTEX: alusrca=1, alusrcb=00, aluop=10 → RTWB.
- RTWB: regdst=1, regwrite → FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch → FETCH.
- IMMEX: alusrca=1, alusrcb=10; aluop=00 for addi, 11 for andi/ori; ext_sign=0 for andi/ori → IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite; ext_sign held as in IMMEX → FETCH.
- JEX: pcsrc=10, pcwrite → FETCH.
- ERROR: all outputs default, no memory requests. Stays until reset.
- Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and on mem_ready. Increments each cycle in those states with mem_ready=0.
- Timeout: if MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0 → ERROR, mem_timeout set. So the trap fires on the MEM_TIMEOUT-th consecutive not-ready cycle; mem_ready in that same cycle wins.
- retired increments on every transition into FETCH from MEMWB, MEMWR, RTWB, BEQEX, IMMWB or JEX. Wraps 2^CNT_W-1 → 0.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, beq 3, addi/andi/ori 4, j 3. Each not-ready cycle adds one.
- Reset mid-instruction: abandon immediately, no further writes, retired not incremented.

Test Plan:
- mem_ready=1 constantly, op=100011 → states 0,1,2,3,4,0; regwrite and memtoreg=1 only in state 4; retired=1 after 5 cycles.
- op=001100 → ext_sign=0 and aluop=11 in IMMEX/IMMWB; op=001000 → ext_sign=1, aluop=00; retired increments once each.
- FETCH with mem_ready low 3 cycles then high → irwrite/pcwrite pulse exactly once, in the 4th cycle; memread high all 4 cycles.
- MEM_TIMEOUT=16, mem_ready held 0 in MEMRD → ERROR on the 16th cycle in MEMRD; mem_timeout=1, memread=0 afterwards. With mem_ready=1 on cycle 16 → MEMWB, no trap.
- op=111111 → ERROR after DECODE with illegal_op=1 sticky. Assert reset mid-ERROR → FETCH, flags clear, retired=0.
- CNT_W=4: run 16 op=000010 instructions → retired wraps 15→0. Assert reset during RTEX → no regwrite follows.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle MIPS control FSM and the datapath.
// The master side is the controller; the slave side is the datapath/IR.
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             pcwrite;
  logic             branch;
  logic [1:0]       pcsrc;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             regdst;
  logic             memtoreg;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic             ext_sign;
  logic             illegal_op;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, pcsrc, iord, memread, memwrite, irwrite,
           regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, ext_sign,
           illegal_op, mem_timeout, retired, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, pcsrc, iord, memread, memwrite, irwrite,
           regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, ext_sign,
           illegal_op, mem_timeout, retired, state_dbg
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: steps each instruction through the shared
// single-ALU datapath, stalls on mem_ready and traps bad opcodes/timeouts.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 on mem_ready
// DECODE | branch target precompute, dispatch on op
// MEMADR | base + sign-extended offset
// MEMRD  | load data read, waits for mem_ready
// MEMWB  | MDR -> rt
// MEMWR  | store data write, waits for mem_ready
// RTEX   | R-type ALU op by funct
// RTWB   | ALUOut -> rd
// BEQEX  | compare, conditional PC load
// IMMEX  | immediate ALU op
// IMMWB  | ALUOut -> rt
// JEX    | jump target -> PC
// ERROR  | trapped, idle until reset
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  mc_control_fsm_if.master bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TO_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7,
    S_BEQEX  = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JEX   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  state_t             state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;
  logic               timeout_q;
  logic               mem_state;
  logic               timeout_hit;
  logic               logic_imm;

  assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready &&
                       (wait_cnt == TO_LAST);
  assign logic_imm   = (bus.op == OP_ANDI) || (bus.op == OP_ORI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // non-memory states hold the counter at zero, so every memory state starts fresh
      if (mem_state && !bus.mem_ready) wait_cnt <= wait_cnt + 1'b1;
      else                             wait_cnt <= '0;

      case (state)
        S_FETCH: begin
          if (timeout_hit) begin
            state     <= S_ERROR;
            timeout_q <= 1'b1;
          end else if (bus.mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW:              state <= S_MEMADR;
            OP_R:                      state <= S_RTEX;
            OP_BEQ:                    state <= S_BEQEX;
            OP_ADDI, OP_ANDI, OP_ORI:  state <= S_IMMEX;
            OP_J:                      state <= S_JEX;
            default: begin
              state     <= S_ERROR;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (timeout_hit) begin
            state     <= S_ERROR;
            timeout_q <= 1'b1;
          end else if (bus.mem_ready) state <= S_MEMWB;
        end
        S_MEMWR: begin
          if (timeout_hit) begin
            state     <= S_ERROR;
            timeout_q <= 1'b1;
          end else if (bus.mem_ready) begin
            state     <= S_FETCH;
            retired_q <= retired_q + 1'b1;
          end
        end
        S_RTEX:  state <= S_RTWB;
        S_IMMEX: state <= S_IMMWB;
        S_MEMWB, S_RTWB, S_BEQEX, S_IMMWB, S_JEX: begin
          state     <= S_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.iord     = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.ext_sign = 1'b1;
    case (state)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        // the only Mealy terms; gated so reset shows a clean FETCH
        bus.irwrite = bus.mem_ready && !reset;
        bus.pcwrite = bus.mem_ready && !reset;
      end
      S_DECODE: bus.alusrcb = 2'b11;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.memread = 1'b1;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_RTEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_RTWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BEQEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        bus.branch  = 1'b1;
      end
      S_IMMEX: begin
        bus.alusrca  = 1'b1;
        bus.alusrcb  = 2'b10;
        bus.aluop    = logic_imm ? 2'b11 : 2'b00;
        bus.ext_sign = !logic_imm;
      end
      S_IMMWB: begin
        bus.regwrite = 1'b1;
        bus.ext_sign = !logic_imm;
      end
      S_JEX: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.retired     = retired_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.mem_timeout = timeout_q;
  assign bus.state_dbg   = state;
endmodule
